// File: rtl/data_memory_lsu.sv
// Dual-port byte-addressed RV32 data memory with load/store front end per port.
// Build option DMEM_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged on pN_err.
module data_memory_lsu_port #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wmask,
  output logic [31:0] wlane,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err
);
  typedef struct packed {
    logic        we;
    logic        bad;
    logic [1:0]  size;
    logic [1:0]  off;
    logic        uns;
    logic [31:0] word;
  } stg_t;

  logic        bad;
  logic [1:0]  off;
  stg_t        head, tail;
  logic        tail_vld;
  logic [31:0] sh, ext;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign bad = (size == 2'b01 && offset[0]) || (size[1] && offset != 2'b00);
`else
  assign bad = 1'b0;
`endif

  // Offset with the alignment-breaking low bits dropped; the access proceeds aligned.
  always_comb begin
    off = 2'b00;
    case (size)
      2'b00:   off = offset;
      2'b01:   off = {offset[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

  always_comb begin
    wmask = 4'h0;
    wlane = wdata;
    case (size)
      2'b00:   wlane = {4{wdata[7:0]}};
      2'b01:   wlane = {2{wdata[15:0]}};
      default: wlane = wdata;
    endcase
    if (req && we && !bad) begin
      case (size)
        2'b00:   wmask = 4'b0001 << off;
        2'b01:   wmask = 4'b0011 << off;
        default: wmask = 4'hF;
      endcase
    end
  end

  assign head = {we, bad, size, off, uns, rword};

  generate
    if (READ_LATENCY == 2) begin : g_stage
      stg_t mid;
      logic mid_vld;
      always_ff @(posedge clk) begin
        if (rst) mid_vld <= 1'b0;
        else     mid_vld <= req;
        mid <= head;
      end
      assign tail     = mid;
      assign tail_vld = mid_vld;
    end else begin : g_direct
      assign tail     = head;
      assign tail_vld = req;
    end
  endgenerate

  assign sh = tail.word >> {tail.off, 3'b000};

  always_comb begin
    ext = sh;
    case (tail.size)
      2'b00:   ext = {{24{~tail.uns & sh[7]}}, sh[7:0]};
      2'b01:   ext = {{16{~tail.uns & sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= 1'b0;
      rdata  <= 32'h0;
      err    <= 1'b0;
    end else begin
      rvalid <= tail_vld & ~tail.we;
      err    <= tail_vld & tail.bad;
      if (tail_vld & ~tail.we) rdata <= tail.bad ? 32'h0 : ext;
    end
  end
endmodule

module data_memory_lsu #(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [1:0]            p0_size,
  input  logic                  p0_unsigned,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [1:0]            p1_size,
  input  logic                  p1_unsigned,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  p1_err
);
  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  generate
    if (DATA_WIDTH != 32) begin : g_dw_chk
      $error("data_memory_lsu: DATA_WIDTH must be 32");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_rl_chk
      $error("data_memory_lsu: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-3:0] idx0, idx1;
  logic [3:0]            m0, m1;
  logic [31:0]           l0, l1, rw0, rw1;

  assign idx0 = p0_addr[ADDR_WIDTH-1:2];
  assign idx1 = p1_addr[ADDR_WIDTH-1:2];
  assign rw0  = mem[idx0];
  assign rw1  = mem[idx1];

  // Port 1 is written second so it wins any overlapping byte lane.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (m0[b]) mem[idx0][8*b +: 8] <= l0[8*b +: 8];
      if (m1[b]) mem[idx1][8*b +: 8] <= l1[8*b +: 8];
    end
  end

  data_memory_lsu_port #(.READ_LATENCY(READ_LATENCY)) u_p0 (
    .clk(clk), .rst(rst), .req(p0_req), .we(p0_we), .size(p0_size), .uns(p0_unsigned),
    .offset(p0_addr[1:0]), .wdata(p0_wdata), .rword(rw0), .wmask(m0), .wlane(l0),
    .rvalid(p0_rvalid), .rdata(p0_rdata), .err(p0_err)
  );

  data_memory_lsu_port #(.READ_LATENCY(READ_LATENCY)) u_p1 (
    .clk(clk), .rst(rst), .req(p1_req), .we(p1_we), .size(p1_size), .uns(p1_unsigned),
    .offset(p1_addr[1:0]), .wdata(p1_wdata), .rword(rw1), .wmask(m1), .wlane(l1),
    .rvalid(p1_rvalid), .rdata(p1_rdata), .err(p1_err)
  );
endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: vector tables plus hand sequences, responses checked via per-port queues.
module tb_data_memory_lsu;
  localparam int RL = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        p0_req = 0, p0_we = 0, p0_unsigned = 0, p1_req = 0, p1_we = 0, p1_unsigned = 0;
  logic [1:0]  p0_size = 0, p1_size = 0;
  logic [9:0]  p0_addr = 0, p1_addr = 0;
  logic [31:0] p0_wdata = 0, p1_wdata = 0;
  logic        p0_rvalid, p0_err, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;

  data_memory_lsu #(.ADDR_WIDTH(10), .READ_LATENCY(RL), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_unsigned(p0_unsigned),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_unsigned(p1_unsigned),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; logic vld; logic err; logic [31:0] data; } exp_t;
  typedef struct {
    int port; logic we; logic [1:0] size; logic uns; logic [9:0] addr;
    logic [31:0] wdata; logic [31:0] exp; logic exp_err;
  } vec_t;

  exp_t q0[$], q1[$];
  vec_t tbl_a[$], tbl_b[$];
  int   checks = 0, failures = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {vld,err,data}=%h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_res(input int port, input logic vld, input logic er, input logic [31:0] data);
    exp_t e;
    e.due = cyc + RL; e.vld = vld; e.err = er; e.data = data;
    if (port == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic drive(input int port, input logic we, input logic [1:0] size, input logic uns,
                       input logic [9:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      p0_req = 1; p0_we = we; p0_size = size; p0_unsigned = uns; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = 1; p1_we = we; p1_size = size; p1_unsigned = uns; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    p0_req = 0; p1_req = 0;
  endtask

  task automatic ld(input int port, input logic [1:0] size, input logic uns, input logic [9:0] addr,
                    input logic [31:0] exp, input logic er);
    drive(port, 1'b0, size, uns, addr, 32'h0);
    expect_res(port, 1'b1, er, exp);
    tick();
  endtask

  task automatic st(input int port, input logic [1:0] size, input logic [9:0] addr,
                    input logic [31:0] wdata, input logic er);
    drive(port, 1'b1, size, 1'b0, addr, wdata);
    if (er) expect_res(port, 1'b0, 1'b1, 32'h0);
    tick();
  endtask

  task automatic apply(input vec_t v);
    if (v.we) st(v.port, v.size, v.addr, v.wdata, v.exp_err);
    else      ld(v.port, v.size, v.uns, v.addr, v.exp, v.exp_err);
  endtask

  task automatic mon_port(input int port, input logic rv, input logic er, input logic [31:0] rd);
    exp_t e;
    bit   hit = 0;
    if (port == 0) begin
      if (q0.size() > 0 && q0[0].due == cyc) begin e = q0.pop_front(); hit = 1; end
    end else begin
      if (q1.size() > 0 && q1[0].due == cyc) begin e = q1.pop_front(); hit = 1; end
    end
    if (hit) chk($sformatf("p%0d response cyc %0d", port, cyc), {rv, er, e.vld ? rd : 32'h0}, {e.vld, e.err, e.data});
    else     chk($sformatf("p%0d idle cyc %0d", port, cyc), {rv, er, 32'h0}, 34'h0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_port(0, p0_rvalid, p0_err, p0_rdata);
      mon_port(1, p1_rvalid, p1_err, p1_rdata);
    end
  end

  initial begin
    // port, we, size, uns, addr, wdata, expected rdata, expected err
    tbl_a.push_back('{0, 1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 32'h0, 1'b0});
    tbl_a.push_back('{0, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 32'hDEADBEEF, 1'b0});
    tbl_a.push_back('{0, 1'b1, 2'd2, 1'b0, 10'h020, 32'h80FF7F01, 32'h0, 1'b0});
    tbl_a.push_back('{0, 1'b0, 2'd0, 1'b0, 10'h023, 32'h0, 32'hFFFFFF80, 1'b0});
    tbl_a.push_back('{1, 1'b0, 2'd0, 1'b1, 10'h023, 32'h0, 32'h00000080, 1'b0});
    tbl_a.push_back('{0, 1'b0, 2'd1, 1'b0, 10'h022, 32'h0, 32'hFFFF80FF, 1'b0});
    tbl_a.push_back('{0, 1'b0, 2'd1, 1'b0, 10'h020, 32'h0, 32'h00007F01, 1'b0});
    tbl_a.push_back('{1, 1'b0, 2'd1, 1'b1, 10'h022, 32'h0, 32'h000080FF, 1'b0});
    tbl_a.push_back('{1, 1'b1, 2'd2, 1'b0, 10'h030, 32'h00000000, 32'h0, 1'b0});
    tbl_a.push_back('{1, 1'b1, 2'd0, 1'b0, 10'h031, 32'h55AA11AB, 32'h0, 1'b0});
    tbl_a.push_back('{1, 1'b0, 2'd2, 1'b0, 10'h030, 32'h0, 32'h0000AB00, 1'b0});
    tbl_a.push_back('{0, 1'b1, 2'd1, 1'b0, 10'h032, 32'hFFFF1234, 32'h0, 1'b0});
    tbl_a.push_back('{1, 1'b0, 2'd3, 1'b0, 10'h030, 32'h0, 32'h1234AB00, 1'b0});
    tbl_a.push_back('{1, 1'b0, 2'd0, 1'b0, 10'h031, 32'h0, 32'hFFFFFFAB, 1'b0});
    tbl_a.push_back('{0, 1'b0, 2'd0, 1'b1, 10'h033, 32'h0, 32'h00000012, 1'b0});
    tbl_a.push_back('{0, 1'b1, 2'd2, 1'b0, 10'h040, 32'h00000000, 32'h0, 1'b0});

    // misalignment, run with mem@0x040 = 0xCAFEF00D
    tbl_b.push_back('{0, 1'b0, 2'd2, 1'b0, 10'h042, 32'h0, TRAP ? 32'h0 : 32'hCAFEF00D, TRAP});
    tbl_b.push_back('{0, 1'b1, 2'd1, 1'b0, 10'h041, 32'h00009999, 32'h0, TRAP});
    tbl_b.push_back('{0, 1'b0, 2'd2, 1'b0, 10'h040, 32'h0, TRAP ? 32'hCAFEF00D : 32'hCAFE9999, 1'b0});
    tbl_b.push_back('{1, 1'b0, 2'd1, 1'b0, 10'h043, 32'h0, TRAP ? 32'h0 : 32'hFFFFCAFE, TRAP});
    tbl_b.push_back('{1, 1'b0, 2'd0, 1'b0, 10'h041, 32'h0, TRAP ? 32'hFFFFFFF0 : 32'hFFFFFF99, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset p0", {p0_rvalid, p0_err, p0_rdata}, 34'h0);
    chk("reset p1", {p1_rvalid, p1_err, p1_rdata}, 34'h0);
    rst = 0;
    mon_en = 1;

    foreach (tbl_a[i]) apply(tbl_a[i]);

    // same-word stores from both ports: port 1 owns the overlapping low half
    drive(0, 1'b1, 2'd2, 1'b0, 10'h040, 32'h11111111);
    drive(1, 1'b1, 2'd1, 1'b0, 10'h040, 32'h00002222);
    tick();
    ld(0, 2'd2, 1'b0, 10'h040, 32'h11112222, 1'b0);

    // load and store on the same word: load sees pre-store data
    drive(0, 1'b0, 2'd2, 1'b0, 10'h040, 32'h0);
    expect_res(0, 1'b1, 1'b0, 32'h11112222);
    drive(1, 1'b1, 2'd2, 1'b0, 10'h040, 32'hCAFEF00D);
    tick();
    ld(0, 2'd2, 1'b0, 10'h040, 32'hCAFEF00D, 1'b0);

    foreach (tbl_b[i]) apply(tbl_b[i]);
    repeat (RL + 1) tick();

    // reset flush: loads in flight and during reset never respond
    drive(0, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
    tick();
    rst = 1;
    drive(1, 1'b0, 2'd2, 1'b0, 10'h010, 32'h0);
    tick();
    rst = 0;
    repeat (RL + 1) tick();
    chk("flush p0 outputs", {p0_rvalid, p0_err, p0_rdata}, 34'h0);
    chk("flush p1 outputs", {p1_rvalid, p1_err, p1_rdata}, 34'h0);

    ld(0, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 1'b0);
    ld(1, 2'd0, 1'b1, 10'h033, 32'h00000012, 1'b0);
    repeat (RL + 2) tick();
    chk("p0 rdata hold", {p0_rvalid, p0_err, p0_rdata}, {2'b00, 32'hDEADBEEF});
    chk("p1 rdata hold", {p1_rvalid, p1_err, p1_rdata}, {2'b00, 32'h00000012});
    chk("responses outstanding", 34'(q0.size() + q1.size()), 34'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
